// File: rtl/io_unit_fifo.sv
// Buffered IO path for the execution unit. It moves 1-4 bytes per IN/OUT op
// through byte FIFOs that face the UART-side valid/ready streams.
//
// state    | meaning
// IDLE     | accepting IO ops; completes immediately when FIFO level allows
// OUT_WAIT | OUT latched, waiting for N free slots in the output FIFO
// IN_WAIT  | blocking IN latched, waiting for N bytes in the input FIFO
module io_unit_fifo #(
  parameter int OUT_DEPTH = 8,
  parameter int IN_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [5:0]                   ope,
  input  logic [31:0]                  ds_val,
  input  logic [5:0]                   dd,
  input  logic [15:0]                  imm,
  output logic [6:0]                   is_busy,
  output logic [5:0]                   io_addr,
  output logic [31:0]                  io_dd_val,
  input  logic [7:0]                   io_in_data,
  input  logic                         io_in_vld,
  output logic                         io_in_rdy,
  output logic [7:0]                   io_out_data,
  output logic                         io_out_vld,
  input  logic                         io_out_rdy,
  output logic [$clog2(OUT_DEPTH):0]   out_level,
  output logic [$clog2(IN_DEPTH):0]    in_level
);

  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OLW = OAW + 1;
  localparam int ILW = IAW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OUT_WAIT = 2'd1,
    IN_WAIT  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic        io_op, op_in, op_poll;
  logic [2:0]  op_n, cur_n;
  logic [5:0]  lat_dd;
  logic [2:0]  lat_n;
  logic [31:0] lat_data;
  logic        lat_en;

  logic [2:0]  out_push_cnt;
  logic [31:0] out_push_data;
  logic [2:0]  in_pop_cnt;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [31:0] wb_val;
  logic [31:0] in_word;

  logic [OLW-1:0] out_free, out_level_nx;
  logic [ILW-1:0] in_level_nx;
  logic           out_fits, in_avail, out_pop, in_push;

  logic [7:0]     out_mem [OUT_DEPTH];
  logic [OAW-1:0] out_wr_ptr, out_rd_ptr;
  logic [7:0]     in_mem [IN_DEPTH];
  logic [IAW-1:0] in_wr_ptr, in_rd_ptr;

  logic unused_bits;
  assign unused_bits = ^{imm[15:3], ope[5:4]};

  assign io_op   = (ope[2:0] == 3'b011);
  assign op_in   = ope[3];
  assign op_poll = imm[2];
  assign op_n    = {1'b0, imm[1:0]} + 3'd1;

  // In a wait state the decision must use the latched count, not the live bus.
  assign cur_n    = (state == IDLE) ? op_n : lat_n;
  assign out_free = OLW'(OUT_DEPTH) - out_level;
  assign out_fits = (out_free >= OLW'(cur_n));
  assign in_avail = (in_level >= ILW'(cur_n));

  assign is_busy = {6'b0, (state != IDLE) | io_op};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (io_op) begin
          if (!op_in) begin
            if (!out_fits) state_nx = OUT_WAIT;
          end else if (!in_avail && !op_poll) begin
            state_nx = IN_WAIT;
          end
        end
      end
      OUT_WAIT: if (out_fits) state_nx = IDLE;
      IN_WAIT:  if (in_avail) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_push_cnt  = '0;
    out_push_data = lat_data;
    in_pop_cnt    = '0;
    wb_en         = 1'b0;
    wb_addr       = lat_dd;
    wb_val        = '0;
    lat_en        = 1'b0;
    case (state)
      IDLE: begin
        out_push_data = ds_val;
        wb_addr       = dd;
        if (io_op) begin
          lat_en = 1'b1;
          if (!op_in) begin
            if (out_fits) out_push_cnt = op_n;
          end else if (in_avail) begin
            in_pop_cnt = op_n;
            wb_en      = 1'b1;
            wb_val     = in_word;
          end else if (op_poll) begin
            wb_en  = 1'b1;
            wb_val = '1;
          end
        end
      end
      OUT_WAIT: if (out_fits) out_push_cnt = lat_n;
      IN_WAIT: begin
        if (in_avail) begin
          in_pop_cnt = lat_n;
          wb_en      = 1'b1;
          wb_val     = in_word;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < cur_n) in_word[8*i +: 8] = in_mem[in_rd_ptr + IAW'(i)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_dd   <= '0;
      lat_n    <= '0;
      lat_data <= '0;
    end else if (lat_en) begin
      lat_dd   <= dd;
      lat_n    <= op_n;
      lat_data <= ds_val;
    end
  end

  // A write-back to register 0 is a discard, so nothing is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_addr   <= '0;
      io_dd_val <= '0;
    end else if (wb_en && (wb_addr != 6'd0)) begin
      io_addr   <= wb_addr;
      io_dd_val <= wb_val;
    end else begin
      io_addr   <= '0;
      io_dd_val <= '0;
    end
  end

  assign out_pop      = io_out_vld & io_out_rdy;
  assign out_level_nx = out_level + OLW'(out_push_cnt) - OLW'(out_pop);
  assign io_out_data  = out_mem[out_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_level  <= '0;
      io_out_vld <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < out_push_cnt) out_mem[out_wr_ptr + OAW'(i)] <= out_push_data[8*i +: 8];
      end
      out_wr_ptr <= out_wr_ptr + OAW'(out_push_cnt);
      out_rd_ptr <= out_rd_ptr + OAW'(out_pop);
      out_level  <= out_level_nx;
      io_out_vld <= (out_level_nx != '0);
    end
  end

  assign in_push     = io_in_vld & io_in_rdy;
  assign in_level_nx = in_level + ILW'(in_push) - ILW'(in_pop_cnt);

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= io_in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_level  <= '0;
      io_in_rdy <= 1'b0;
    end else begin
      in_wr_ptr <= in_wr_ptr + IAW'(in_push);
      in_rd_ptr <= in_rd_ptr + IAW'(in_pop_cnt);
      in_level  <= in_level_nx;
      io_in_rdy <= (in_level_nx < ILW'(IN_DEPTH));
    end
  end

endmodule
